ysyx_25060170_ifetch: RTL and testbench

YSYX_25060170_IFETCH -- requirements
Module: ysyx_25060170_IFETCH

---
 rtl/ysyx_25060170_pkg.sv | 20 ++
 rtl/ysyx_25060170_ifetch.sv | 199 +++++++++++++++++++
 tb/tb_ysyx_25060170_ifetch.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25060170_pkg.sv
// Shared definitions for the instruction-fetch unit: FSM state encoding,
// the all-zero instruction placed on a timed-out fetch, and the default
// timeout length.
package ysyx_25060170_pkg;

    // Fetch FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // waiting for a PC from the PC stage
        ST_REQ  = 2'd1,   // presenting the read request to memory
        ST_WAIT = 2'd2,   // request accepted, waiting for the response
        ST_OUT  = 2'd3    // holding the instruction for the IDU
    } ifetch_state_e;

    // Instruction word reported on a timed-out fetch (never executed: inst_err=1)
    localparam logic [31:0] INST_ZERO = 32'h0000_0000;

    // Default number of WAIT cycles before a fetch is declared timed out
    localparam int unsigned TIMEOUT_CYCLES_DEF = 16;

endpackage

// File: rtl/ysyx_25060170_ifetch.sv
// Instruction-fetch unit: takes one PC at a time, issues a single read to
// instruction memory, and hands the returned word to the IDU. A flush from
// the jump path kills the fetch in flight; a response already owed by memory
// for a killed fetch is swallowed through the drop flag.
//
// Optional feature: define YSYX_IFETCH_TIMEOUT_EN to add a WAIT-state
// watchdog. After TIMEOUT_CYCLES WAIT cycles without a response the unit
// presents inst=0 with inst_err=1 and drops the late response when it comes.
// Without the macro inst_err is tied low and WAIT waits indefinitely.
module ysyx_25060170_ifetch
    import ysyx_25060170_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    // PC stage
    input  logic [31:0] pc_i,
    input  logic        pc_valid,
    output logic        pc_ready,
    input  logic        flush,
    // instruction memory
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    // IDU
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_err
);

    ifetch_state_e r_state;
    ifetch_state_e w_state_next;

    logic [31:0] r_pc;          // latched fetch PC (request address and inst_pc)
    logic [31:0] r_inst;        // latched instruction word
    logic        r_drop;        // next response in WAIT belongs to a dead fetch
    logic        w_drop_next;
    logic        w_pc_load;
    logic        w_inst_load;
    logic        w_timeout;     // watchdog fires and the fetch reports an error
    logic        w_timeout_hit; // watchdog limit reached this WAIT cycle

`ifdef YSYX_IFETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    // The limit is hit on the last silent WAIT cycle, so OUT follows exactly
    // TIMEOUT_CYCLES WAIT cycles after the memory handshake.
    assign w_timeout_hit = (r_state == ST_WAIT) && !mem_resp_valid
                         && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counter: zero outside WAIT, counts silent WAIT cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (r_state != ST_WAIT) begin
            r_cnt <= '0;
        end else if (!mem_resp_valid && !w_timeout_hit) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Error flag travels with the instruction it describes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_inst_load) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign inst_err = r_err;
`else
    // The timeout length only matters when the watchdog is built in.
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;

    assign w_timeout_hit = 1'b0;
    assign inst_err      = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state is written with <= so every register samples
        // the pre-edge values and the order of statements cannot matter.
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; flush is examined first in every state
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        w_state_next = r_state;
        w_drop_next  = r_drop;
        w_pc_load    = 1'b0;
        w_inst_load  = 1'b0;
        w_timeout    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!flush && pc_valid) begin
                    w_state_next = ST_REQ;
                    w_pc_load    = 1'b1;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    // Memory now owes a response; a flush here must swallow it.
                    w_state_next = ST_WAIT;
                    if (flush) begin
                        w_drop_next = 1'b1;
                    end
                end else if (flush) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid) begin
                    if (flush || r_drop) begin
                        // The response is for a dead fetch: discard it.
                        w_state_next = ST_IDLE;
                        w_drop_next  = 1'b0;
                    end else begin
                        w_state_next = ST_OUT;
                        w_inst_load  = 1'b1;
                    end
                end else if (flush) begin
                    w_drop_next = 1'b1;
                end else if (w_timeout_hit) begin
                    if (r_drop) begin
                        // Already killed: nothing worth reporting to the IDU.
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_OUT;
                        w_timeout    = 1'b1;
                        w_drop_next  = 1'b1;
                    end
                end
            end
            ST_OUT: begin
                if (flush || inst_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath holding registers: PC, instruction word and drop flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc   <= '0;
            r_inst <= '0;
            r_drop <= 1'b0;
        end else begin
            r_drop <= w_drop_next;
            if (w_pc_load) begin
                r_pc <= pc_i;
            end
            if (w_inst_load) begin
                r_inst <= mem_resp_data;
            end else if (w_timeout) begin
                r_inst <= INST_ZERO;
            end
        end
    end

    // Handshake outputs decoded from the state; nothing is accepted in reset
    always_comb begin
        pc_ready      = 1'b0;
        mem_req_valid = 1'b0;
        inst_valid    = 1'b0;
        unique case (r_state)
            ST_IDLE: pc_ready      = rst && !flush;
            ST_REQ:  mem_req_valid = 1'b1;
            ST_OUT:  inst_valid    = 1'b1;
            default: ;
        endcase
    end

    assign mem_req_addr = r_pc;
    assign inst         = r_inst;
    assign inst_pc      = r_pc;

endmodule

// File: tb/tb_ysyx_25060170_ifetch.sv
// Directed testbench for ysyx_25060170_ifetch. Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge. Built with
// YSYX_IFETCH_TIMEOUT_EN it also exercises the watchdog (TIMEOUT_CYCLES=4);
// without it, it confirms WAIT holds indefinitely.
module tb_ysyx_25060170_ifetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        pc_valid;
    logic        pc_ready;
    logic        flush;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_err;

    int n_cmp = 0;
    int n_bad = 0;

    ysyx_25060170_ifetch #(.TIMEOUT_CYCLES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_i           (pc_i),
        .pc_valid       (pc_valid),
        .pc_ready       (pc_ready),
        .flush          (flush),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_err       (inst_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Complete fetch with zero-wait memory; starts and ends 1 ns after a rising edge in IDLE
    task automatic fetch(input string tag, input logic [31:0] pc, input logic [31:0] data);
        pc_i = pc;
        pc_valid = 1'b1;
        @(negedge clk);
        check({tag, ".pc_ready"}, 32'(pc_ready), 32'd1);
        tick();
        pc_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        check({tag, ".req_valid"}, 32'(mem_req_valid), 32'd1);
        check({tag, ".req_addr"}, mem_req_addr, pc);
        tick();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data = data;
        @(negedge clk);
        check({tag, ".early_valid"}, 32'(inst_valid), 32'd0);
        tick();
        mem_resp_valid = 1'b0;
        @(negedge clk);
        check({tag, ".inst_valid"}, 32'(inst_valid), 32'd1);
        check({tag, ".inst"}, inst, data);
        check({tag, ".inst_pc"}, inst_pc, pc);
        check({tag, ".inst_err"}, 32'(inst_err), 32'd0);
        tick();
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        @(negedge clk);
        check({tag, ".consumed"}, 32'(inst_valid), 32'd0);
        tick();
    endtask

    // Accept a PC and complete the memory handshake; ends in WAIT
    task automatic to_wait(input logic [31:0] pc);
        pc_i = pc;
        pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        pc_i = '0;
        pc_valid = 1'b0;
        flush = 1'b0;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data = '0;
        inst_ready = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst.pc_ready", 32'(pc_ready), 32'd0);
        check("rst.req_valid", 32'(mem_req_valid), 32'd0);
        check("rst.inst_valid", 32'(inst_valid), 32'd0);
        check("rst.inst", inst, 32'd0);
        check("rst.inst_pc", inst_pc, 32'd0);
        check("rst.req_addr", mem_req_addr, 32'd0);
        check("rst.inst_err", 32'(inst_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Zero-wait path
        fetch("zw", 32'h8000_0000, 32'h0000_0413);

        // Request backpressure: 5 cycles without mem_req_ready
        pc_i = 32'h8000_0008;
        pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        pc_i = 32'h1111_1111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp.req_valid", 32'(mem_req_valid), 32'd1);
            check("bp.req_addr", mem_req_addr, 32'h8000_0008);
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data = 32'h1234_5678;
        tick();
        mem_resp_valid = 1'b0;
        mem_resp_data = 32'h0;
        // Instruction backpressure: 4 cycles without inst_ready
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp.inst_valid", 32'(inst_valid), 32'd1);
            check("bp.inst", inst, 32'h1234_5678);
            check("bp.inst_pc", inst_pc, 32'h8000_0008);
            tick();
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        @(negedge clk);
        check("bp.consumed", 32'(inst_valid), 32'd0);
        tick();

        // Flush in WAIT: the response is dropped, then a new PC fetches cleanly
        to_wait(32'h8000_0004);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data = 32'hDEAD_BEEF;
        @(negedge clk);
        check("fw.no_valid", 32'(inst_valid), 32'd0);
        tick();
        mem_resp_valid = 1'b0;
        @(negedge clk);
        check("fw.idle_valid", 32'(inst_valid), 32'd0);
        check("fw.idle_ready", 32'(pc_ready), 32'd1);
        tick();
        fetch("fw.next", 32'h8000_0100, 32'h0010_0093);

        // Flush on the memory handshake cycle: response is still dropped
        pc_i = 32'h8000_0104;
        pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        mem_req_ready = 1'b1;
        flush = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        flush = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data = 32'hDEAD_BEEF;
        tick();
        mem_resp_valid = 1'b0;
        @(negedge clk);
        check("fh.no_valid", 32'(inst_valid), 32'd0);
        check("fh.idle_ready", 32'(pc_ready), 32'd1);
        tick();

        // Flush in REQ before the handshake: request withdrawn
        pc_i = 32'h8000_0108;
        pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("fr.req_valid", 32'(mem_req_valid), 32'd0);
        check("fr.idle_ready", 32'(pc_ready), 32'd1);
        // Stray response while IDLE is ignored
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data = 32'hFFFF_FFFF;
        tick();
        mem_resp_valid = 1'b0;
        @(negedge clk);
        check("stray.inst_valid", 32'(inst_valid), 32'd0);
        tick();
        fetch("fr.next", 32'h8000_010C, 32'h0000_0013);

        // Flush together with inst_ready in OUT
        to_wait(32'h8000_0200);
        mem_resp_valid = 1'b1;
        mem_resp_data = 32'h0000_0067;
        tick();
        mem_resp_valid = 1'b0;
        @(negedge clk);
        check("fo.inst_valid", 32'(inst_valid), 32'd1);
        tick();
        flush = 1'b1;
        inst_ready = 1'b1;
        tick();
        flush = 1'b0;
        inst_ready = 1'b0;
        @(negedge clk);
        check("fo.dropped", 32'(inst_valid), 32'd0);
        tick();

        // Flush together with pc_valid in IDLE: PC not accepted
        pc_i = 32'h8000_0300;
        pc_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        check("fi.pc_ready", 32'(pc_ready), 32'd0);
        tick();
        pc_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("fi.req_valid", 32'(mem_req_valid), 32'd0);
        check("fi.idle_ready", 32'(pc_ready), 32'd1);
        tick();

`ifdef YSYX_IFETCH_TIMEOUT_EN
        // Timeout after 4 silent WAIT cycles
        to_wait(32'h8000_0400);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("to.wait_valid", 32'(inst_valid), 32'd0);
            tick();
        end
        @(negedge clk);
        check("to.inst_valid", 32'(inst_valid), 32'd1);
        check("to.inst_err", 32'(inst_err), 32'd1);
        check("to.inst", inst, 32'd0);
        check("to.inst_pc", inst_pc, 32'h8000_0400);
        tick();
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        // Late response reaching WAIT is dropped
        to_wait(32'h8000_0404);
        mem_resp_valid = 1'b1;
        mem_resp_data = 32'hBAD0_BAD0;
        tick();
        mem_resp_valid = 1'b0;
        @(negedge clk);
        check("to.late_valid", 32'(inst_valid), 32'd0);
        check("to.late_idle", 32'(pc_ready), 32'd1);
        tick();
        fetch("to.next", 32'h8000_0408, 32'h0000_0513);
`else
        // Without the watchdog, WAIT holds for a long silent stretch
        to_wait(32'h8000_0400);
        begin
            int n_early = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (inst_valid !== 1'b0 || pc_ready !== 1'b0) n_early++;
                tick();
            end
            check("nt.held_wait", 32'(n_early), 32'd0);
        end
        mem_resp_valid = 1'b1;
        mem_resp_data = 32'h0000_0513;
        tick();
        mem_resp_valid = 1'b0;
        @(negedge clk);
        check("nt.inst_valid", 32'(inst_valid), 32'd1);
        check("nt.inst", inst, 32'h0000_0513);
        check("nt.inst_err", 32'(inst_err), 32'd0);
        tick();
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
`endif

        // Reset asserted in WAIT clears outputs immediately
        to_wait(32'h8000_0010);
        #1;
        rst = 1'b0;
        #1;
        check("ar.req_valid", 32'(mem_req_valid), 32'd0);
        check("ar.inst_valid", 32'(inst_valid), 32'd0);
        check("ar.pc_ready", 32'(pc_ready), 32'd0);
        check("ar.inst", inst, 32'd0);
        check("ar.inst_pc", inst_pc, 32'd0);
        check("ar.req_addr", mem_req_addr, 32'd0);
        check("ar.inst_err", 32'(inst_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        // Response arriving after release is ignored
        mem_resp_valid = 1'b1;
        mem_resp_data = 32'hCAFE_F00D;
        tick();
        mem_resp_valid = 1'b0;
        @(negedge clk);
        check("ar.post_valid", 32'(inst_valid), 32'd0);
        check("ar.post_inst", inst, 32'd0);
        check("ar.post_ready", 32'(pc_ready), 32'd1);
        tick();
        fetch("ar.next", 32'h8000_0020, 32'h0000_0093);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
